decodificador: RTL and testbench

//  Receiving end of the codificador link. Samples the 5-bit 4B/5B code word m1..m5
//  on each rising edge of ready and decodes it back to a,b,c,d.

---
 rtl/decodificador.sv | 114 +++++++++++
 tb/tb_decodificador.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decodificador.sv
// rtl/decodificador.sv - 4B/5B code word decoder with link lock tracking
// Optional DECOD_ERRCNT_EN builds the saturating invalid-word counter; otherwise err_cnt is tied to 0.
module decodificador #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             m1,
  input  logic             m2,
  input  logic             m3,
  input  logic             m4,
  input  logic             m5,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             valid,
  output logic             err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {HUNT, LOCK} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  state_t     state;
  logic [3:0] run;
  logic       ready_q;
  logic       new_word;
  logic [4:0] code;
  logic       hit;
  logic [3:0] nib;

  assign new_word = ready & ~ready_q;
  assign code     = {m1, m2, m3, m4, m5};

  always_comb begin
    hit = 1'b1;
    nib = 4'h0;
    case (code)
      5'b11110: nib = 4'h0;
      5'b01001: nib = 4'h1;
      5'b10100: nib = 4'h2;
      5'b10101: nib = 4'h3;
      5'b01010: nib = 4'h4;
      5'b01011: nib = 4'h5;
      5'b01110: nib = 4'h6;
      5'b01111: nib = 4'h7;
      5'b10010: nib = 4'h8;
      5'b10011: nib = 4'h9;
      5'b10110: nib = 4'hA;
      5'b10111: nib = 4'hB;
      5'b11010: nib = 4'hC;
      5'b11011: nib = 4'hD;
      5'b11100: nib = 4'hE;
      5'b11101: nib = 4'hF;
      default:  hit = 1'b0;
    endcase
  end

  // Outputs and lock state all move on the edge that sees the ready rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q      <= 1'b0;
      {a, b, c, d} <= 4'h0;
      valid        <= 1'b0;
      err          <= 1'b0;
      locked       <= 1'b0;
      state        <= HUNT;
      run          <= 4'd0;
    end else begin
      ready_q <= ready;
      valid   <= 1'b0;
      err     <= 1'b0;
      if (new_word) begin
        if (hit) begin
          {a, b, c, d} <= nib;
          valid        <= 1'b1;
          if (state == HUNT) begin
            if (run + 4'd1 >= LOCK_N) begin
              state  <= LOCK;
              locked <= 1'b1;
              run    <= LOCK_N;
            end else begin
              run <= run + 4'd1;
            end
          end
        end else begin
          err    <= 1'b1;
          state  <= HUNT;
          locked <= 1'b0;
          run    <= 4'd0;
        end
      end
    end
  end

`ifdef DECOD_ERRCNT_EN
  // Counts alongside the err pulse so err_cnt already reflects it while err is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (new_word && !hit && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_decodificador.sv
// tb/tb_decodificador.sv - scoreboard bench for decodificador (LOCK_CNT=4, ERR_W=2)
module tb_decodificador;

  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             ready;
  logic             m1, m2, m3, m4, m5;
  logic             a, b, c, d;
  logic             valid, err, locked;
  logic [ERR_W-1:0] err_cnt;

  decodificador #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5),
    .a(a), .b(b), .c(c), .d(d),
    .valid(valid), .err(err), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_err;
    bit [3:0] nib;
    bit       lck;
    int       cnt;
  } exp_t;

  exp_t     sb[$];
  bit [4:0] enc_tbl[16];
  int       n_tests = 0;
  int       n_fail  = 0;
  int       n_valid = 0;
  int       n_err   = 0;

  bit [3:0] m_nib;
  bit       m_locked;
  int       m_run;
  int       m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int max_cnt();
`ifdef DECOD_ERRCNT_EN
    return (1 << ERR_W) - 1;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_nib = 4'h0; m_locked = 1'b0; m_run = 0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic model_word(input bit [4:0] code);
    exp_t e;
    int   idx = -1;
    for (int i = 0; i < 16; i++) if (enc_tbl[i] == code) idx = i;
    if (idx >= 0) begin
      m_nib = 4'(idx);
      if (!m_locked) begin
        m_run++;
        if (m_run >= LOCK_CNT) m_locked = 1'b1;
      end
      e.is_err = 1'b0;
    end else begin
      m_run = 0;
      m_locked = 1'b0;
      if (m_cnt < max_cnt()) m_cnt++;
      e.is_err = 1'b1;
    end
    e.nib = m_nib; e.lck = m_locked; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic send(input bit [4:0] code, input int hold);
    @(negedge clk);
    {m1, m2, m3, m4, m5} = code;
    ready = 1'b1;
    model_word(code);
    repeat (hold) @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", sb.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (reset && (valid || err)) begin
      exp_t e;
      if (valid) n_valid++;
      if (err) n_err++;
      check("excl", {31'd0, valid & err}, 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        check("err_flag", {31'd0, err}, {31'd0, e.is_err});
        check("abcd", {28'd0, a, b, c, d}, {28'd0, e.nib});
        check("locked", {31'd0, locked}, {31'd0, e.lck});
        check("err_cnt", {30'd0, err_cnt}, 32'(e.cnt));
      end
    end
  end

  initial begin
    int v0, e0;
    enc_tbl = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
                5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101};
    reset = 1'b0; ready = 1'b0; {m1, m2, m3, m4, m5} = 5'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_abcd", {28'd0, a, b, c, d}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_err_cnt", {30'd0, err_cnt}, 0);
    reset = 1'b1;

    // ramp to lock
    for (int i = 0; i < 4; i++) begin
      send(enc_tbl[i], 1);
      if (i < 3) begin
        drain();
        check("hunt_locked", {31'd0, locked}, 0);
      end
    end
    drain();
    check("lock_after_4", {31'd0, locked}, 1);

    // invalid while locked
    send(5'b00000, 1);
    drain();
    check("hold_abcd", {28'd0, a, b, c, d}, 3);
    check("unlock", {31'd0, locked}, 0);

    // level-high ready gives a single sample
    v0 = n_valid;
    send(5'b11101, 10);
    drain();
    check("one_valid", n_valid - v0, 1);
    check("abcd_f", {28'd0, a, b, c, d}, 15);

    // saturation
    send(5'b00000, 1); send(5'b11111, 1); send(5'b00001, 1);
    send(5'b10000, 1); send(5'b01000, 1);
    drain();
    check("err_cnt_sat", {30'd0, err_cnt}, 32'(max_cnt()));

    // loopback of every nibble
    e0 = n_err;
    for (int i = 0; i < 16; i++) send(enc_tbl[i], 1 + (i % 3));
    drain();
    check("loop_no_err", n_err - e0, 0);
    check("loop_locked", {31'd0, locked}, 1);

    // reset on the same cycle as the ready edge
    @(negedge clk);
    v0 = n_valid;
    {m1, m2, m3, m4, m5} = enc_tbl[5];
    ready = 1'b1;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("mid_valid", {31'd0, valid}, 0);
    check("mid_abcd", {28'd0, a, b, c, d}, 0);
    check("mid_locked", {31'd0, locked}, 0);
    check("mid_err_cnt", {30'd0, err_cnt}, 0);
    @(negedge clk); ready = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_no_valid", n_valid - v0, 0);

    // ready already high when reset releases
    reset = 1'b0;
    {m1, m2, m3, m4, m5} = enc_tbl[7];
    ready = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    model_word(enc_tbl[7]);
    repeat (3) @(negedge clk);
    ready = 1'b0;
    drain();
    check("rel_abcd", {28'd0, a, b, c, d}, 7);
    check("rel_locked", {31'd0, locked}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
